bcd_seq_adder: RTL and testbench
================================

BCD_SEQ_ADDER -- requirements
Module: bcd_seq_adder

Interface
REQ-001 SHALL have parameter NDIG, default 4, meaning the number of BCD digits per operand (legal values 1..8).
REQ-002 SHALL have port Clock, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port Resetn, input, 1 bit: reset that is synchronous and active-low.
REQ-004 SHALL have port Start, input, 1 bit: request to begin an addition.
REQ-005 SHALL have port A, input, 4*NDIG bits: BCD operand, digit 0 in bits [3:0].
REQ-006 SHALL have port B, input, 4*NDIG bits: BCD operand, same layout as A.
REQ-007 SHALL have port Cin, input, 1 bit: carry into digit 0.
REQ-008 SHALL have port Busy, output, 1 bit: operation in progress; Start is ignored while Busy is high.
REQ-009 SHALL have port Done, output, 1 bit: one-cycle pulse marking the result as valid.
REQ-010 SHALL have port Sum, output, 4*NDIG bits: BCD result.
REQ-011 SHALL have port Cout, output, 1 bit: carry out of the most significant digit.
REQ-012 SHALL have port Err, output, 1 bit: set when any captured operand digit exceeds 9.

Function
REQ-013 SHALL implement the FSM states IDLE, ADD and DONE.
REQ-014 SHALL accept Start only in IDLE or DONE.
- On acceptance: capture A, B, Cin into internal registers.
- Clear the digit index to 0; clear Sum, Cout and Err.
- Enter ADD next cycle.
REQ-015 SHALL ignore Start while in ADD, with no effect on registers or outputs.
REQ-016 SHALL process exactly one digit per ADD cycle, least significant digit first.
- Writes Sum digit[idx] and the carry register.
- Increments idx.
REQ-017 SHALL compute each digit as the 5-bit value t = a + b + c (max 19).
- If t > 9: digit = (t + 6) mod 16, carry = 1.
- Otherwise: digit = t[3:0], carry = 0.
REQ-018 SHALL move ADD to DONE after the cycle that processes digit NDIG-1, with Cout = the final carry.
REQ-019 SHALL assert Done for exactly one cycle while in DONE, then go to IDLE unless Start is accepted in that same cycle.
REQ-020 SHALL assert Done in the (NDIG+1)th cycle after the edge that samples Start (NDIG+1 cycles of latency).
REQ-021 SHALL evaluate the error check on the capture cycle. If any digit of A or B exceeds 9:
- Set Err = 1.
- Skip ADD and enter DONE on the next cycle.
- Keep Sum = 0 and Cout = 0.
REQ-022 SHALL hold Sum, Cout and Err stable from DONE until the next accepted Start or reset.
REQ-023 SHALL drive Busy = 1 exactly while in ADD.
REQ-024 SHALL not use the A, B or Cin ports after capture; changing them mid-operation has no effect.

Reset
REQ-025 SHALL, when Resetn = 0 at a clock edge, force IDLE, idx = 0, Sum = 0, Cout = 0, Err = 0, Busy = 0 and Done = 0, with all outputs reading zero in the following cycle.
REQ-026 SHALL let reset take priority over Start and abandon an in-flight ADD with no Done pulse.

Structure
REQ-027 SHALL place the following in a shared package bcd_pkg:
- the state enumeration;
- the constant BCD_MAX = 9;
- the constant BCD_ADJ = 6.
REQ-028 SHALL contain exactly one combinational sub-module, bcd_digit_add, with inputs a[3:0], b[3:0], ci and outputs s[3:0], co, implementing REQ-017.
REQ-029 SHALL instantiate bcd_digit_add once and share it across all digits through an idx-selected operand mux.

Verification (NDIG = 4)
REQ-030 SHALL cover: A=0x1234, B=0x5678, Cin=0, Start -> Busy for 4 cycles, Done in cycle 5, Sum=0x6912, Cout=0, Err=0.
REQ-031 SHALL cover: A=0x9999, B=0x0001, Cin=0 -> Sum=0x0000, Cout=1; then A=0x9999, B=0x9999, Cin=1 -> Sum=0x9999, Cout=1.
REQ-032 SHALL cover: A=0x12A4, B=0x0000 -> Done in cycle 2, Err=1, Sum=0x0000, Cout=0, Busy never high.
REQ-033 SHALL cover: Start pulsed again in ADD cycle 2 with new operands -> ignored, first result 0x6912 delivered unchanged.
REQ-034 SHALL cover: Resetn=0 during ADD cycle 3 -> next cycle IDLE, all outputs 0, no Done pulse; a subsequent Start for 0x0005+0x0005 -> Sum=0x0010.
REQ-035 SHALL cover: Start held high through the DONE cycle -> new operation accepted back-to-back, Busy rises the next cycle, Done pulses again after NDIG+1 cycles.

Source files
------------

// File: rtl/bcd_pkg.sv
// Shared definitions for the sequential BCD adder: FSM states and BCD digit constants.
package bcd_pkg;

   // Controller states: waiting, adding one digit per cycle, result valid.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ADD  = 2'd1,
      DONE = 2'd2
   } bcd_state_e;

   // Largest legal BCD digit and the correction added when a digit sum overflows it.
   localparam logic [3:0] BCD_MAX = 4'd9;
   localparam logic [3:0] BCD_ADJ = 4'd6;

   // True when a 4-bit nibble is not a legal BCD digit.
   function automatic logic bcd_digit_bad(input logic [3:0] d);
      return (d > BCD_MAX);
   endfunction

endpackage

// File: rtl/bcd_digit_add.sv
// Single-digit BCD adder: a + b + ci with decimal correction. Purely combinational.
module bcd_digit_add
   import bcd_pkg::*;
(
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  logic       ci,
   output logic [3:0] s,
   output logic       co
);

   logic [4:0] t;

   // Binary sum (at most 19), then wrap into 0..9 with a decimal carry when it exceeds 9.
   always_comb begin
      t = {1'b0, a} + {1'b0, b} + {4'b0000, ci};
      if (t > {1'b0, BCD_MAX}) begin
         s  = t[3:0] + BCD_ADJ;
         co = 1'b1;
      end else begin
         s  = t[3:0];
         co = 1'b0;
      end
   end

endmodule

// File: rtl/bcd_seq_adder.sv
// Sequential BCD adder: captures two NDIG-digit operands and adds them one digit per
// cycle through a single shared digit adder, least significant digit first.
module bcd_seq_adder
   import bcd_pkg::*;
#(
   parameter int NDIG = 4
)(
   input  logic              Clock,
   input  logic              Resetn,
   input  logic              Start,
   input  logic [4*NDIG-1:0] A,
   input  logic [4*NDIG-1:0] B,
   input  logic              Cin,
   output logic              Busy,
   output logic              Done,
   output logic [4*NDIG-1:0] Sum,
   output logic              Cout,
   output logic              Err
);

   localparam int IDXW = (NDIG > 1) ? $clog2(NDIG) : 1;
   localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NDIG - 1);

   bcd_state_e        state_q, state_d;
   logic [IDXW-1:0]   idx_q, idx_d;
   logic [4*NDIG-1:0] a_q, a_d;
   logic [4*NDIG-1:0] b_q, b_d;
   logic [4*NDIG-1:0] sum_q, sum_d;
   logic              carry_q, carry_d;
   logic              cout_q, cout_d;
   logic              err_q, err_d;
   // Set for the single cycle after capturing illegal operands; the FSM waits in
   // IDLE for that cycle so the Done pulse lands one cycle later without ever
   // raising Busy, and a new Start is not taken meanwhile.
   logic              skip_q, skip_d;

   logic [2*NDIG-1:0] bad_dig;
   logic              op_bad;
   logic              accept;
   logic [3:0]        dig_a, dig_b, dig_s;
   logic              dig_co;

   // Per-digit legality flags for both operand ports, sampled at the capture edge.
   generate
      for (genvar gi = 0; gi < NDIG; gi++) begin : g_chk
         assign bad_dig[gi]        = bcd_digit_bad(A[4*gi +: 4]);
         assign bad_dig[NDIG + gi] = bcd_digit_bad(B[4*gi +: 4]);
      end
   endgenerate

   assign op_bad = |bad_dig;
   assign accept = Start && !skip_q && (state_q != ADD);

   // Operand mux: the digit index picks which captured digit pair feeds the adder.
   assign dig_a = a_q[{idx_q, 2'b00} +: 4];
   assign dig_b = b_q[{idx_q, 2'b00} +: 4];

   bcd_digit_add u_digit (
      .a  (dig_a),
      .b  (dig_b),
      .ci (carry_q),
      .s  (dig_s),
      .co (dig_co)
   );

   // Next-state and datapath updates; a new operation overrides whatever the state would do.
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      a_d     = a_q;
      b_d     = b_q;
      sum_d   = sum_q;
      carry_d = carry_q;
      cout_d  = cout_q;
      err_d   = err_q;
      skip_d  = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (skip_q) begin
               state_d = DONE;
            end
         end
         ADD: begin
            sum_d[{idx_q, 2'b00} +: 4] = dig_s;
            carry_d = dig_co;
            idx_d   = idx_q + 1'b1;
            if (idx_q == LAST_IDX) begin
               cout_d  = dig_co;
               state_d = DONE;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      if (accept) begin
         a_d     = A;
         b_d     = B;
         carry_d = Cin;
         idx_d   = '0;
         sum_d   = '0;
         cout_d  = 1'b0;
         err_d   = op_bad;
         if (op_bad) begin
            skip_d  = 1'b1;
            state_d = IDLE;
         end else begin
            state_d = ADD;
         end
      end
   end

   // State and datapath registers with synchronous active-low reset.
   always_ff @(posedge Clock) begin
      if (!Resetn) begin
         state_q <= IDLE;
         idx_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         sum_q   <= '0;
         carry_q <= 1'b0;
         cout_q  <= 1'b0;
         err_q   <= 1'b0;
         skip_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         a_q     <= a_d;
         b_q     <= b_d;
         sum_q   <= sum_d;
         carry_q <= carry_d;
         cout_q  <= cout_d;
         err_q   <= err_d;
         skip_q  <= skip_d;
      end
   end

   assign Busy = (state_q == ADD);
   assign Done = (state_q == DONE);
   assign Sum  = sum_q;
   assign Cout = cout_q;
   assign Err  = err_q;

endmodule

// File: tb/tb_bcd_seq_adder.sv
// Directed testbench for bcd_seq_adder with NDIG = 4.
module tb_bcd_seq_adder;

   logic        Clock;
   logic        Resetn;
   logic        Start;
   logic [15:0] A;
   logic [15:0] B;
   logic        Cin;
   logic        Busy;
   logic        Done;
   logic [15:0] Sum;
   logic        Cout;
   logic        Err;

   int checks = 0;
   int errors = 0;
   logic [15:0] last_sum = 16'h0000;

   bcd_seq_adder #(.NDIG(4)) dut (
      .Clock  (Clock),
      .Resetn (Resetn),
      .Start  (Start),
      .A      (A),
      .B      (B),
      .Cin    (Cin),
      .Busy   (Busy),
      .Done   (Done),
      .Sum    (Sum),
      .Cout   (Cout),
      .Err    (Err)
   );

   initial Clock = 1'b0;
   always #5 Clock = ~Clock;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Called at a falling edge. Drives Start with the operands, follows the operation
   // cycle by cycle, and checks Busy/Done every cycle plus the result in the Done cycle.
   // poke > 0 re-pulses Start with different operands in that ADD cycle.
   task automatic run_op(input string name, input logic [15:0] a, input logic [15:0] b,
                         input logic cin, input logic [15:0] es, input logic ec,
                         input logic ee, input bit idle_first, input int poke);
      int lat;
      lat = ee ? 2 : 5;
      if (idle_first) begin
         Start = 1'b0;
         @(negedge Clock);
         chk({name, " idle_done"}, Done, 1'b0);
         chk({name, " idle_sum_hold"}, Sum, last_sum);
      end
      A = a; B = b; Cin = cin; Start = 1'b1;
      for (int k = 1; k <= lat; k++) begin
         @(negedge Clock);
         chk($sformatf("%s busy_c%0d", name, k), Busy, (!ee && k < lat));
         chk($sformatf("%s done_c%0d", name, k), Done, (k == lat));
         if (k == poke) begin
            Start = 1'b1; A = 16'h1111; B = 16'h2222; Cin = 1'b1;
         end else begin
            Start = 1'b0; A = 16'h7777; B = 16'h8888; Cin = 1'b1;
         end
      end
      chk({name, " sum"}, Sum, es);
      chk({name, " cout"}, Cout, ec);
      chk({name, " err"}, Err, ee);
      last_sum = es;
      $display("op %s: A=%h B=%h Cin=%0d -> Sum=%h Cout=%0d Err=%0d", name, a, b, cin, Sum, Cout, Err);
   endtask

   initial begin
      Resetn = 1'b0; Start = 1'b0; A = 16'h0; B = 16'h0; Cin = 1'b0;
      repeat (2) @(negedge Clock);
      chk("rst busy", Busy, 1'b0);
      chk("rst done", Done, 1'b0);
      chk("rst sum", Sum, 16'h0000);
      chk("rst cout", Cout, 1'b0);
      chk("rst err", Err, 1'b0);
      $display("reset: Busy=%0d Done=%0d Sum=%h Cout=%0d Err=%0d", Busy, Done, Sum, Cout, Err);
      Resetn = 1'b1;

      run_op("basic", 16'h1234, 16'h5678, 1'b0, 16'h6912, 1'b0, 1'b0, 1'b1, 0);
      run_op("carry_out", 16'h9999, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 0);
      run_op("all_nines", 16'h9999, 16'h9999, 1'b1, 16'h9999, 1'b1, 1'b0, 1'b1, 0);
      run_op("cin_ripple", 16'h0499, 16'h0001, 1'b1, 16'h0501, 1'b0, 1'b0, 1'b1, 0);
      run_op("bad_digit", 16'h12A4, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 0);
      run_op("after_err", 16'h0321, 16'h0456, 1'b0, 16'h0777, 1'b0, 1'b0, 1'b1, 0);
      run_op("restart_ign", 16'h1234, 16'h5678, 1'b0, 16'h6912, 1'b0, 1'b0, 1'b1, 2);

      // Reset asserted during the third ADD cycle abandons the operation.
      Start = 1'b0;
      @(negedge Clock);
      A = 16'h1234; B = 16'h5678; Cin = 1'b0; Start = 1'b1;
      @(negedge Clock);
      Start = 1'b0;
      @(negedge Clock);
      @(negedge Clock);
      chk("midrst busy_c3", Busy, 1'b1);
      Resetn = 1'b0;
      @(negedge Clock);
      chk("midrst busy", Busy, 1'b0);
      chk("midrst done", Done, 1'b0);
      chk("midrst sum", Sum, 16'h0000);
      chk("midrst cout", Cout, 1'b0);
      chk("midrst err", Err, 1'b0);
      $display("reset mid-ADD: Busy=%0d Done=%0d Sum=%h", Busy, Done, Sum);
      Resetn = 1'b1;
      @(negedge Clock);
      chk("midrst no_done", Done, 1'b0);
      last_sum = 16'h0000;
      run_op("post_rst", 16'h0005, 16'h0005, 1'b0, 16'h0010, 1'b0, 1'b0, 1'b0, 0);

      // Back-to-back: Start issued during the Done cycle of the previous operation.
      run_op("b2b_first", 16'h0001, 16'h0002, 1'b0, 16'h0003, 1'b0, 1'b0, 1'b1, 0);
      run_op("b2b_second", 16'h4321, 16'h1111, 1'b0, 16'h5432, 1'b0, 1'b0, 1'b0, 0);
      run_op("b2b_err", 16'h0000, 16'hF000, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 0);
      run_op("b2b_third", 16'h5000, 16'h5000, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 0);

      Start = 1'b0;
      @(negedge Clock);
      chk("final idle_done", Done, 1'b0);
      chk("final sum_hold", Sum, 16'h0000);
      chk("final cout_hold", Cout, 1'b1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
